urv_mem_arbiter: RTL and testbench

Shares one single-port memory bus between the core's instruction-fetch port and its data load/store port. The block sits between the core and the shared memory or bus bridge, with one transaction outstanding at a time. Data accesses have priority over fetches, with a bounded-burst rule so fetches are not starved. A per-transaction timeout covers a bus that never acknowledges.

---
 rtl/urv_mem_arbiter_if.sv | 40 ++++
 rtl/urv_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_urv_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/urv_mem_arbiter_if.sv
// Bundle between the arbiter, the core's fetch/data ports and the shared bus.
// master = arbiter side, slave = core/bus side.
interface urv_mem_arbiter_if;
    logic [31:0] im_addr_i;
    logic [31:0] im_data_o;
    logic        im_valid_o;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_data_s_i;
    logic [3:0]  dm_data_select_i;
    logic        dm_load_i;
    logic        dm_store_i;
    logic        dm_ready_o;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;
    logic        bus_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [3:0]  bus_sel_o;
    logic        bus_ack_i;
    logic [31:0] bus_data_i;

    modport master (
        input  im_addr_i, dm_addr_i, dm_data_s_i, dm_data_select_i,
        input  dm_load_i, dm_store_i, bus_ack_i, bus_data_i,
        output im_data_o, im_valid_o, dm_ready_o, dm_data_l_o,
        output dm_load_done_o, dm_store_done_o, bus_err_o,
        output bus_req_o, bus_we_o, bus_addr_o, bus_data_o, bus_sel_o
    );

    modport slave (
        output im_addr_i, dm_addr_i, dm_data_s_i, dm_data_select_i,
        output dm_load_i, dm_store_i, bus_ack_i, bus_data_i,
        input  im_data_o, im_valid_o, dm_ready_o, dm_data_l_o,
        input  dm_load_done_o, dm_store_done_o, bus_err_o,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_data_o, bus_sel_o
    );
endinterface

// File: rtl/urv_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory bus between fetch and data.
// Data has priority, bounded by a burst limit; a timeout aborts dead cycles.
module urv_mem_arbiter #(
    parameter int unsigned g_max_data_burst = 4,
    parameter int unsigned g_timeout        = 255
) (
    input logic               clk_i,
    input logic               rst_n_i,
    urv_mem_arbiter_if.master mif
);
    localparam int unsigned BW = $clog2(g_max_data_burst + 2);
    localparam int unsigned TW = $clog2(g_timeout + 2);
    localparam logic [BW-1:0] BMAX = BW'(g_max_data_burst);
    localparam logic [TW-1:0] TLAST =
        TW'((g_timeout == 0) ? 0 : g_timeout - 1);
    localparam bit TMO_EN   = (g_timeout != 0);
    localparam bit BURST_EN = (g_max_data_burst != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IFETCH,
        S_DLOAD,
        S_DSTORE
    } state_t;

    state_t        state;
    logic [BW-1:0] burst_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [31:0]   f_addr;
    logic [31:0]   im_data;
    logic          im_valid;
    logic [31:0]   dm_data_l;
    logic          load_done;
    logic          store_done;
    logic          bus_err;
    logic          bus_req;
    logic          bus_we;
    logic [31:0]   bus_addr;
    logic [31:0]   bus_data;
    logic [3:0]    bus_sel;

    logic data_go;
    logic tmo_hit;

    assign data_go = (mif.dm_load_i || mif.dm_store_i) &&
                     (!BURST_EN || (burst_cnt < BMAX));
    assign tmo_hit = TMO_EN && (tmo_cnt == TLAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= S_IDLE;
            burst_cnt  <= '0;
            tmo_cnt    <= '0;
            f_addr     <= '0;
            im_data    <= '0;
            im_valid   <= 1'b0;
            dm_data_l  <= '0;
            load_done  <= 1'b0;
            store_done <= 1'b0;
            bus_err    <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_data   <= '0;
            bus_sel    <= '0;
        end else begin
            im_valid   <= 1'b0;
            load_done  <= 1'b0;
            store_done <= 1'b0;
            bus_err    <= 1'b0;
            if (state == S_IDLE) begin
                tmo_cnt <= '0;
                bus_req <= 1'b1;
                unique case (1'b1)
                    (data_go && mif.dm_store_i): begin
                        state    <= S_DSTORE;
                        bus_we   <= 1'b1;
                        bus_addr <= mif.dm_addr_i;
                        bus_data <= mif.dm_data_s_i;
                        bus_sel  <= mif.dm_data_select_i;
                    end
                    (data_go && !mif.dm_store_i): begin
                        state    <= S_DLOAD;
                        bus_we   <= 1'b0;
                        bus_addr <= mif.dm_addr_i;
                        bus_data <= '0;
                        bus_sel  <= 4'hF;
                    end
                    default: begin
                        state    <= S_IFETCH;
                        bus_we   <= 1'b0;
                        bus_addr <= mif.im_addr_i;
                        bus_data <= '0;
                        bus_sel  <= 4'hF;
                        f_addr   <= mif.im_addr_i;
                    end
                endcase
                if (!data_go)
                    burst_cnt <= '0;
                else if (burst_cnt != BMAX)
                    burst_cnt <= burst_cnt + BW'(1);
            end else if (mif.bus_ack_i) begin
                state   <= S_IDLE;
                bus_req <= 1'b0;
                case (state)
                    S_DLOAD: begin
                        dm_data_l <= mif.bus_data_i;
                        load_done <= 1'b1;
                    end
                    S_DSTORE: store_done <= 1'b1;
                    default: begin
                        // A fetch whose address moved on is dropped silently.
                        if (mif.im_addr_i == f_addr) begin
                            im_data  <= mif.bus_data_i;
                            im_valid <= 1'b1;
                        end
                    end
                endcase
            end else if (tmo_hit) begin
                state   <= S_IDLE;
                bus_req <= 1'b0;
                case (state)
                    S_DLOAD: begin
                        dm_data_l <= '0;
                        load_done <= 1'b1;
                        bus_err   <= 1'b1;
                    end
                    S_DSTORE: begin
                        store_done <= 1'b1;
                        bus_err    <= 1'b1;
                    end
                    default: ;
                endcase
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

    assign mif.dm_ready_o      = (state == S_IDLE);
    assign mif.im_data_o       = im_data;
    assign mif.im_valid_o      = im_valid;
    assign mif.dm_data_l_o     = dm_data_l;
    assign mif.dm_load_done_o  = load_done;
    assign mif.dm_store_done_o = store_done;
    assign mif.bus_err_o       = bus_err;
    assign mif.bus_req_o       = bus_req;
    assign mif.bus_we_o        = bus_we;
    assign mif.bus_addr_o      = bus_addr;
    assign mif.bus_data_o      = bus_data;
    assign mif.bus_sel_o       = bus_sel;
endmodule

// File: tb/tb_urv_mem_arbiter.sv
// Scoreboard bench for urv_mem_arbiter: directed traffic, queued expectations,
// a negedge monitor checking responses and grants.
module tb_urv_mem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    urv_mem_arbiter_if a ();
    urv_mem_arbiter_if b ();

    urv_mem_arbiter #(.g_max_data_burst(4), .g_timeout(8)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .mif(a.master));
    urv_mem_arbiter #(.g_max_data_burst(0), .g_timeout(8)) dut_s (
        .clk_i(clk), .rst_n_i(rst_n), .mif(b.master));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] ad);
        if (ad == 32'h100) return 32'h0000_0013;
        if (ad == 32'h200) return 32'h0000_0093;
        return ad ^ 32'hA5A5_0000;
    endfunction

    // bus model for the main DUT: programmable wait states or no ack
    logic noack = 1'b0;
    int   waits = 0;
    int   wcnt_a = 0;
    assign a.bus_ack_i  = a.bus_req_o && !noack && (wcnt_a == waits);
    assign a.bus_data_i = a.bus_ack_i ? rd(a.bus_addr_o) : 32'hFFFF_FFFF;
    always @(posedge clk)
        if (!a.bus_req_o || a.bus_ack_i) wcnt_a <= 0;
        else wcnt_a <= wcnt_a + 1;

    // strict-priority DUT: zero-wait bus, load held high forever
    assign b.bus_ack_i        = b.bus_req_o;
    assign b.bus_data_i       = rd(b.bus_addr_o);
    assign b.im_addr_i        = 32'h100;
    assign b.dm_addr_i        = 32'h6000;
    assign b.dm_data_s_i      = 32'h0;
    assign b.dm_data_select_i = 4'hF;
    assign b.dm_load_i        = 1'b1;
    assign b.dm_store_i       = 1'b0;

    typedef struct packed {
        logic        ld;
        logic [31:0] data;
        logic        err;
    } dexp_t;

    dexp_t       dq[$];
    bit          gq[$];
    bit          gq_en = 1'b0;
    logic [31:0] exp_iword = 32'h13;
    int          ivalid_cnt = 0;
    int          fetch_b = 0;
    int          data_b = 0;
    logic        prev_req = 1'b0;
    logic        prev_b = 1'b0;
    logic [68:0] prev_bus = '0;
    dexp_t       e;
    bit          g;

    always @(negedge clk) begin
        if (rst_n) begin
            if (|{a.im_valid_o, a.dm_load_done_o, a.dm_store_done_o})
                chk("excl", $countones({a.im_valid_o, a.dm_load_done_o,
                    a.dm_store_done_o}) <= 1, 1);
            if (a.im_valid_o) begin
                ivalid_cnt++;
                chk("iword", a.im_data_o, exp_iword);
            end
            if (a.dm_load_done_o || a.dm_store_done_o) begin
                if (dq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: ld=%b st=%b want none",
                             a.dm_load_done_o, a.dm_store_done_o);
                end else begin
                    e = dq.pop_front();
                    chk("done_kind", a.dm_load_done_o, e.ld);
                    if (e.ld) chk("ldata", a.dm_data_l_o, e.data);
                    chk("done_err", a.bus_err_o, e.err);
                end
            end else if (a.bus_err_o) begin
                chk("lone_err", a.bus_err_o, 0);
            end
            if (a.bus_req_o && !prev_req && gq_en && gq.size() != 0) begin
                g = gq.pop_front();
                chk("grant_is_data", a.bus_addr_o >= 32'h1000, g);
            end
            if (a.bus_req_o && prev_req)
                chk("bus_stable", {a.bus_addr_o, a.bus_data_o, a.bus_sel_o,
                    a.bus_we_o} == prev_bus, 1);
            if (b.bus_req_o && !prev_b) begin
                if (b.bus_addr_o < 32'h1000) fetch_b++;
                else data_b++;
            end
            prev_req = a.bus_req_o;
            prev_b   = b.bus_req_o;
            prev_bus = {a.bus_addr_o, a.bus_data_o, a.bus_sel_o, a.bus_we_o};
        end else begin
            prev_req = 1'b0;
            prev_b   = 1'b0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        for (n = 0; n < 40; n++) begin
            if (a.dm_ready_o) break;
            step();
        end
        if (n == 40) chk("ready_timeout", a.dm_ready_o, 1);
    endtask

    task automatic do_load(input logic [31:0] ad, input logic push);
        wait_ready();
        a.dm_addr_i = ad;
        a.dm_load_i = 1'b1;
        if (push) dq.push_back('{1'b1, rd(ad), 1'b0});
        @(posedge clk);
        #1;
        a.dm_load_i = 1'b0;
    endtask

    initial begin
        int k;
        int n0;
        a.im_addr_i        = 32'h100;
        a.dm_addr_i        = 32'h0;
        a.dm_data_s_i      = 32'h0;
        a.dm_data_select_i = 4'hF;
        a.dm_load_i        = 1'b0;
        a.dm_store_i       = 1'b0;
        repeat (3) step();

        chk("rst_bus_req", a.bus_req_o, 0);
        chk("rst_im_valid", a.im_valid_o, 0);
        chk("rst_ld_done", a.dm_load_done_o, 0);
        chk("rst_err", a.bus_err_o, 0);
        chk("rst_addr", a.bus_addr_o, 0);
        chk("rst_ready", a.dm_ready_o, 1);

        // idle fetch loop: one valid word every 2 cycles
        rst_n = 1'b1;
        n0 = ivalid_cnt;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 0) begin
                chk("f_req", a.bus_req_o, 1);
                chk("f_sel", a.bus_sel_o, 4'hF);
                chk("f_we", a.bus_we_o, 0);
            end
        end
        chk("fetch_rate", ivalid_cnt - n0, 5);

        // store with 3 wait states
        wait_ready();
        waits = 3;
        a.dm_addr_i        = 32'h2000;
        a.dm_data_s_i      = 32'hDEAD_BEEF;
        a.dm_data_select_i = 4'h3;
        a.dm_store_i       = 1'b1;
        dq.push_back('{1'b0, 32'h0, 1'b0});
        @(posedge clk);
        #1;
        a.dm_store_i = 1'b0;
        for (k = 1; k < 20; k++) begin
            step();
            if (k == 1) begin
                chk("st_we", a.bus_we_o, 1);
                chk("st_sel", a.bus_sel_o, 4'h3);
                chk("st_addr", a.bus_addr_o, 32'h2000);
                chk("st_data", a.bus_data_o, 32'hDEAD_BEEF);
            end
            if (a.dm_store_done_o) break;
        end
        chk("st_latency", k, 5);
        waits = 0;
        a.dm_data_select_i = 4'hF;

        // load held high: D,D,D,D,F,D,D,D,D,F
        repeat (4) step();
        wait_ready();
        for (int i = 0; i < 10; i++) gq.push_back(!(i == 4 || i == 9));
        for (int i = 0; i < 8; i++) dq.push_back('{1'b1, rd(32'h4000), 1'b0});
        a.dm_addr_i = 32'h4000;
        a.dm_load_i = 1'b1;
        gq_en = 1'b1;
        for (int i = 0; i < 60 && gq.size() != 0; i++) step();
        a.dm_load_i = 1'b0;
        gq_en = 1'b0;
        chk("burst_seq_left", gq.size(), 0);

        // fetch address moves while the fetch is on the bus
        for (k = 0; k < 20; k++) begin
            if (a.bus_req_o && a.bus_addr_o == 32'h100) break;
            step();
        end
        chk("found_fetch", k < 20, 1);
        a.im_addr_i = 32'h200;
        exp_iword = 32'h93;
        n0 = ivalid_cnt;
        repeat (3) step();
        chk("fresh_fetch_cnt", ivalid_cnt - n0, 1);

        // bus never acks a load
        wait_ready();
        noack = 1'b1;
        a.dm_addr_i = 32'h3000;
        a.dm_load_i = 1'b1;
        dq.push_back('{1'b1, 32'h0, 1'b1});
        @(posedge clk);
        #1;
        a.dm_load_i = 1'b0;
        k = 0;
        for (int i = 0; i < 30; i++) begin
            if (!a.bus_req_o) break;
            k++;
            @(posedge clk);
            #1;
        end
        chk("tmo_req_cycles", k, 8);
        chk("tmo_done", a.dm_load_done_o, 1);
        chk("tmo_err", a.bus_err_o, 1);
        chk("tmo_ldata", a.dm_data_l_o, 0);
        noack = 1'b0;
        do_load(32'h3004, 1'b1);

        // reset while a load is pending
        wait_ready();
        noack = 1'b1;
        do_load(32'h5000, 1'b0);
        step();
        chk("pend_req", a.bus_req_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_req", a.bus_req_o, 0);
        chk("rst_no_done", a.dm_load_done_o, 0);
        step();
        noack = 1'b0;
        rst_n = 1'b1;
        chk("rst_idle", a.dm_ready_o, 1);
        do_load(32'h5000, 1'b1);

        for (int i = 0; i < 50 && dq.size() != 0; i++) step();
        chk("drain", dq.size(), 0);
        chk("strict_no_fetch", fetch_b, 0);
        chk("strict_data_flow", data_b > 20, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, want finish");
        $fatal(1);
    end
endmodule
